// File: rtl/mips_cpu_pkg.sv
// Shared MIPS-subset encodings: opcodes, funct codes and ALU control values.
package mips_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_ctrl_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit ALU: wrapping add/sub, bitwise and/or, signed set-less-than.
module alu
    import mips_cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  control,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'h0;
        case (alu_ctrl_e'(control))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            default: result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/dmem.sv
// Word-addressed data RAM: combinational read, write on the rising edge.
module dmem #(
    parameter int WORDS = 128,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] RAM [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            RAM[addr] <= wdata;
        end
    end

    assign rdata = RAM[addr];

endmodule

// File: rtl/imem.sv
// Instruction ROM; contents are preloaded hierarchically on ROM from outside.
module imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   rdata
);

    logic [31:0] ROM [WORDS];

    assign rdata = ROM[addr];

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational reads, one clocked write, $0 hardwired to zero.
module regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] RF [32];

    // No bypass: a same-cycle write only becomes visible after the edge.
    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            RF[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : RF[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : RF[ra2];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS subset core: add/sub/and/or/slt, lw, sw, addi, beq, j.
// Reset only holds PC at zero; the word at address 0 keeps executing under reset.
module mips_cpu
    import mips_cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 128
) (
    input  logic clk,
    input  logic rst_
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr, imm_ext;
    logic [31:0] rs_val, rt_val, alu_b, alu_y, mem_rdata, wb_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_addr;
    logic [2:0]  alu_ctrl;
    logic        reg_we, mem_we, use_imm, mem_to_reg, wr_rt, is_beq, is_j, alu_zero;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign imm_ext = sext16(instr[15:0]);

    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        use_imm    = 1'b0;
        mem_to_reg = 1'b0;
        wr_rt      = 1'b0;
        is_beq     = 1'b0;
        is_j       = 1'b0;
        alu_ctrl   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                reg_we = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: reg_we   = 1'b0;
                endcase
            end
            OP_LW: begin
                reg_we     = 1'b1;
                use_imm    = 1'b1;
                mem_to_reg = 1'b1;
                wr_rt      = 1'b1;
            end
            OP_SW: begin
                mem_we  = 1'b1;
                use_imm = 1'b1;
            end
            OP_ADDI: begin
                reg_we  = 1'b1;
                use_imm = 1'b1;
                wr_rt   = 1'b1;
            end
            OP_BEQ: begin
                is_beq   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_J:    is_j = 1'b1;
            default: ;
        endcase
    end

    assign wr_addr  = wr_rt ? rt : rd;
    assign alu_b    = use_imm ? imm_ext : rt_val;
    assign wb_data  = mem_to_reg ? mem_rdata : alu_y;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (is_j) begin
            pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (is_beq && alu_zero) begin
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc_q <= 32'h0;
        end else begin
            pc_q <= pc_d;
        end
    end

    imem #(.WORDS(IMEM_WORDS)) IMem (
        .addr  (pc_q[IAW+1:2]),
        .rdata (instr)
    );

    regfile RegFile (
        .clk (clk),
        .we  (reg_we),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wr_addr),
        .wd  (wb_data),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    alu u_alu (
        .a       (rs_val),
        .b       (alu_b),
        .control (alu_ctrl),
        .result  (alu_y),
        .zero    (alu_zero)
    );

    dmem #(.WORDS(DMEM_WORDS)) DMem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (alu_y[DAW+1:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: an ISA-level interpreter runs alongside the core and all
// architectural state is compared every cycle; directed literals pin key results.
module tb_mips_cpu;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;

    mips_cpu #(.IMEM_WORDS(256), .DMEM_WORDS(128)) dut (
        .clk  (clk),
        .rst_ (rst_)
    );

    always #5 clk = ~clk;

    logic [31:0] m_rom [256];
    logic [31:0] m_rf  [32];
    logic [31:0] m_ram [128];
    logic [31:0] m_pc  = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic set_rom(input int i, input logic [31:0] v);
        dut.IMem.ROM[i] = v;
        m_rom[i] = v;
    endtask

    task automatic set_rf(input int i, input logic [31:0] v);
        dut.RegFile.RF[i] = v;
        m_rf[i] = v;
    endtask

    task automatic set_ram(input int i, input logic [31:0] v);
        dut.DMem.RAM[i] = v;
        m_ram[i] = v;
    endtask

    // ISA interpreter: one instruction per rising edge, PC pinned to 0 under reset.
    task automatic model_step();
        logic [31:0] ins, rsv, rtv, imm, npc, res, ea;
        logic [4:0]  wr;
        bit          we;
        ins = m_rom[m_pc[9:2]];
        rsv = m_rf[ins[25:21]];
        rtv = m_rf[ins[20:16]];
        imm = {{16{ins[15]}}, ins[15:0]};
        npc = m_pc + 32'd4;
        we  = 1'b0;
        wr  = 5'd0;
        res = 32'h0;
        case (ins[31:26])
            6'h00: begin
                wr = ins[15:11];
                we = 1'b1;
                case (ins[5:0])
                    6'h20:   res = rsv + rtv;
                    6'h22:   res = rsv - rtv;
                    6'h24:   res = rsv & rtv;
                    6'h25:   res = rsv | rtv;
                    6'h2A:   res = ($signed(rsv) < $signed(rtv)) ? 32'd1 : 32'd0;
                    default: we = 1'b0;
                endcase
            end
            6'h23: begin
                ea  = rsv + imm;
                wr  = ins[20:16];
                we  = 1'b1;
                res = m_ram[ea[8:2]];
            end
            6'h2B: begin
                ea = rsv + imm;
                m_ram[ea[8:2]] = rtv;
            end
            6'h08: begin
                wr  = ins[20:16];
                we  = 1'b1;
                res = rsv + imm;
            end
            6'h04: if (rsv == rtv) npc = m_pc + 32'd4 + (imm << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            default: ;
        endcase
        if (we && wr != 5'd0) m_rf[wr] = res;
        m_pc = rst_ ? npc : 32'h0;
    endtask

    always @(posedge clk) model_step();
    always @(negedge rst_) m_pc = 32'h0;

    task automatic cmp_state();
        int bad;
        chk("pc", dut.pc_q, m_pc);
        bad = -1;
        for (int i = 0; i < 32; i++)
            if (bad < 0 && dut.RegFile.RF[i] !== m_rf[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL rf[%0d]: got %08h expected %08h", bad, dut.RegFile.RF[bad], m_rf[bad]);
        end
        bad = -1;
        for (int i = 0; i < 128; i++)
            if (bad < 0 && dut.DMem.RAM[i] !== m_ram[i]) bad = i;
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL ram[%0d]: got %08h expected %08h", bad, dut.DMem.RAM[bad], m_ram[bad]);
        end
    endtask

    always @(negedge clk) if (cmp_en) cmp_state();

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_ins();
        int rs, rt, rd, k;
        logic [31:0] fn;
        rs = $urandom_range(7);
        rt = $urandom_range(7);
        rd = $urandom_range(7);
        k  = $urandom_range(11);
        case (k)
            0: fn = 32'h20;
            1: fn = 32'h22;
            2: fn = 32'h24;
            3: fn = 32'h25;
            4: fn = 32'h2A;
            default: fn = 32'($urandom_range(63));
        endcase
        case (k)
            0, 1, 2, 3, 4, 11: return r_ins(rs, rt, rd, int'(fn));
            5:  return i_ins(8'h23, rs, rt, int'($urandom_range(65535)));
            6:  return i_ins(8'h2B, rs, rt, int'($urandom_range(65535)));
            7:  return i_ins(8'h08, rs, rt, int'($urandom_range(65535)));
            8:  return i_ins(8'h04, rs, ($urandom_range(1) == 0) ? rs : rt,
                             int'($urandom_range(16)) - 8);
            9:  return {6'h02, 26'($urandom_range(255))};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) set_rom(i, 32'h0);
        for (int i = 0; i < 32; i++)  set_rf(i, 32'h0);
        for (int i = 0; i < 128; i++) set_ram(i, 32'h0);
        set_rf(1, 32'd5);
        set_rf(2, 32'd7);
        set_rf(7, 32'hFFFF_FFFF);
        set_rom(0, r_ins(1, 2, 3, 32'h20));        // add $3,$1,$2
        set_rom(1, i_ins(8'h2B, 0, 3, 4));         // sw  $3,4($0)
        set_rom(2, i_ins(8'h23, 0, 4, 4));         // lw  $4,4($0)
        set_rom(3, r_ins(4, 1, 5, 32'h22));        // sub $5,$4,$1
        set_rom(4, i_ins(8'h04, 1, 1, 2));         // beq $1,$1,+2
        set_rom(5, i_ins(8'h08, 0, 9, 99));        // skipped
        set_rom(6, i_ins(8'h08, 0, 9, 99));        // skipped
        set_rom(7, r_ins(1, 2, 0, 32'h20));        // add $0,$1,$2
        set_rom(8, r_ins(7, 1, 6, 32'h2A));        // slt $6,$7,$1
        set_rom(9, 32'hFC00_0000);                 // opcode 0x3F
        cmp_en = 1'b1;

        // Two edges under reset: ROM[0] executes each time, PC stays 0.
        @(posedge clk);
        tick();
        chk("rf3_under_reset", dut.RegFile.RF[3], 32'h0000_000C);
        chk("model_rf3", m_rf[3], 32'h0000_000C);
        chk("pc_under_reset", dut.pc_q, 32'h0);
        #2 rst_ = 1'b1;

        tick(); chk("pc_after_first_edge", dut.pc_q, 32'h4);
        tick(); chk("sw_ram1", dut.DMem.RAM[1], 32'h0000_000C);
        tick(); chk("lw_rf4", dut.RegFile.RF[4], 32'h0000_000C);
        tick(); chk("sub_rf5", dut.RegFile.RF[5], 32'h0000_0007);
        chk("model_rf5", m_rf[5], 32'h0000_0007);
        tick(); chk("beq_pc", dut.pc_q, 32'h0000_001C);
        tick(); chk("rf0_zero", dut.RegFile.RF[0], 32'h0);
        chk("skipped_rf9", dut.RegFile.RF[9], 32'h0);
        tick(); chk("slt_rf6", dut.RegFile.RF[6], 32'h1);
        tick(); chk("undef_pc", dut.pc_q, 32'h0000_0028);
        chk("model_pc", m_pc, 32'h0000_0028);
        tick();

        // Asynchronous reset between edges.
        #2 rst_ = 1'b0;
        #1;
        chk("pc_async_reset", dut.pc_q, 32'h0);
        chk("ram1_kept", dut.DMem.RAM[1], 32'h0000_000C);
        chk("rf3_kept", dut.RegFile.RF[3], 32'h0000_000C);
        tick();
        tick();
        #2 rst_ = 1'b1;
        tick();
        tick();

        // Randomized programs and state with sporadic mid-cycle resets.
        for (int run = 0; run < 4; run++) begin
            #2 rst_ = 1'b0;
            for (int i = 0; i < 256; i++) set_rom(i, rand_ins());
            for (int i = 1; i < 32; i++)  set_rf(i, ($urandom_range(3) == 0) ? $urandom : 32'($urandom_range(600)));
            for (int i = 0; i < 128; i++) set_ram(i, $urandom);
            tick();
            #2 rst_ = 1'b1;
            for (int c = 0; c < 700; c++) begin
                tick();
                if ($urandom_range(99) == 0) begin
                    #2 rst_ = 1'b0;
                    #1 chk("pc_async_rand", dut.pc_q, 32'h0);
                    tick();
                    #2 rst_ = 1'b1;
                end
            end
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu.md
MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 Parameter IMEM_WORDS, default 256, sets the instruction ROM depth in 32-bit words.
REQ-002 Parameter DMEM_WORDS, default 128, sets the data RAM depth in 32-bit words.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have no other ports; its state SHALL be observable only through hierarchical paths IMem.ROM, RegFile.RF and DMem.RAM.
REQ-006 Each of IMem.ROM, RegFile.RF and DMem.RAM SHALL be an unpacked array of 32-bit words, loadable by $readmemh and dumpable by $writememh.

Function
REQ-007 The core SHALL be single-cycle: each rising clk retires exactly one instruction, with fetch, decode, execute, memory access and writeback all combinational within the cycle.
REQ-008 PC SHALL be a 32-bit byte address; the fetched word SHALL be IMem.ROM[PC[9:2]]; PC advances by 4 per cycle unless a branch or jump is taken.
REQ-009 R-type instructions (opcode 0x00) SHALL be supported with funct codes add 0x20, sub 0x22, and 0x24, or 0x25 and slt 0x2A; the result is written to rd.
REQ-010 lw (0x23) SHALL write DMem.RAM[(rs+sext(imm))[8:2]] to rt.
REQ-011 sw (0x2B) SHALL write rt to DMem.RAM[(rs+sext(imm))[8:2]] on the rising edge.
REQ-012 addi (0x08) SHALL write rs+sext(imm) to rt.
REQ-013 beq (0x04) SHALL set PC to PC+4+(sext(imm)<<2) when rs==rt, otherwise to PC+4.
REQ-014 j (0x02) SHALL set PC to {PC+4[31:28], target, 2'b00}.
REQ-015 Arithmetic SHALL be 32-bit two's complement, wrap on overflow and raise no exception; slt SHALL be a signed compare.
REQ-016 Unsupported opcodes or funct codes SHALL act as a NOP: no register write, no memory write, PC+4.
REQ-017 The register file SHALL be 32x32 with two combinational read ports and one write port; reads of $0 SHALL return 0 and writes to $0 SHALL be discarded.
REQ-018 A write to the same register as a read within a cycle SHALL make the new value visible only in the next cycle.
REQ-019 Memory addresses SHALL be word-aligned; the low two address bits SHALL be ignored, and addresses beyond the array depth SHALL wrap modulo the depth.

Reset
REQ-020 While rst_ is low, PC SHALL be held at 0, asserted asynchronously.
REQ-021 Reset SHALL NOT clear the register file, DMem or IMem contents, and SHALL NOT gate write enables, so the instruction at address 0 executes on every clock during reset.
REQ-022 On the first rising edge after rst_ deasserts, the instruction at address 0 SHALL execute, and PC SHALL become 4 (or the branch/jump target).
REQ-023 Reset asserted mid-program SHALL return PC to 0 immediately; any write already committed SHALL persist.

Structure
REQ-024 A shared package SHALL hold the opcode constants, funct constants and ALU-control encodings.
REQ-025 Instances SHALL be named IMem, RegFile and DMem, with arrays ROM, RF and RAM respectively.
REQ-026 The ALU SHALL be a separate sub-module named alu (operands a and b, control, result and zero); the control decoder remains in mips_cpu.

Verification
REQ-027 Preload RF[1]=5 and RF[2]=7, and set ROM[0] to "add $3,$1,$2" -> RF[3]=0x0000000C after the second rising edge, while reset is still low.
REQ-028 Set ROM[1] to "sw $3,4($0)" -> RAM[1]=0x0000000C one cycle after the first post-reset edge.
REQ-029 Set ROM[2] to "lw $4,4($0)" and ROM[3] to "sub $5,$4,$1" -> RF[4]=0x0000000C, then RF[5]=0x00000007.
REQ-030 Run "beq $1,$1,+2" at address 0x10 -> next PC=0x1C; run "add $0,$1,$2" -> RF[0] remains 0.
REQ-031 Drop rst_ low asynchronously mid-cycle -> PC reads 0 immediately; RAM[1] and RF[3] retain their values.
REQ-032 Run "slt $6,$7,$1" with RF[7]=0xFFFFFFFF -> RF[6]=1; run an undefined opcode 0x3F -> no state change and PC+4.
